// File: rtl/ecc_alu_pkg.sv
// Shared types for the ECC modular ALU: opcodes, FSM states and the request record.
package ecc_alu_pkg;

  localparam int unsigned ECC_ALU_WIDTH    = 64;
  localparam int unsigned ECC_ALU_ID_WIDTH = 4;
  localparam int unsigned ECC_ALU_RD_WIDTH = 5;

  typedef enum logic [1:0] {
    OP_SETMOD = 2'd0,
    OP_ADD    = 2'd1,
    OP_SUB    = 2'd2,
    OP_NEG    = 2'd3
  } ecc_alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_REDUCE  = 2'd2,
    ST_RESP    = 2'd3
  } ecc_alu_state_e;

  typedef struct packed {
    ecc_alu_op_e                 op;
    logic [ECC_ALU_WIDTH-1:0]    a;
    logic [ECC_ALU_WIDTH-1:0]    b;
    logic [ECC_ALU_ID_WIDTH-1:0] id;
    logic [ECC_ALU_RD_WIDTH-1:0] rd;
  } ecc_alu_req_t;

endpackage

// File: rtl/ecc_mod_correct.sv
// Single-step modular correction of a raw (WIDTH+1)-bit add/sub result against p.
module ecc_mod_correct
  import ecc_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH:0]   raw,
  input  logic [WIDTH-1:0] modulus,
  input  ecc_alu_op_e      op,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH:0]   mod_ext_s;
  logic [WIDTH-1:0] minus_p_s;
  logic [WIDTH-1:0] plus_p_s;

  assign mod_ext_s = {1'b0, modulus};
  assign minus_p_s = raw[WIDTH-1:0] - modulus;
  assign plus_p_s  = raw[WIDTH-1:0] + modulus;

  // ADD folds back once when s >= p; SUB/NEG add p back once on borrow
  always_comb begin
    result = raw[WIDTH-1:0];
    case (op)
      OP_ADD: begin
        if (raw >= mod_ext_s) result = minus_p_s;
        else                  result = raw[WIDTH-1:0];
      end
      OP_SUB, OP_NEG: begin
        if (raw[WIDTH]) result = plus_p_s;
        else            result = raw[WIDTH-1:0];
      end
      default: result = raw[WIDTH-1:0];
    endcase
  end

endmodule

// File: rtl/ecc_modular_alu.sv
// Modular ADD/SUB/NEG engine with its own modulus register, one operation in flight,
// valid/ready request and result channels.
module ecc_modular_alu
  import ecc_alu_pkg::*;
#(
  parameter int unsigned      WIDTH     = 64,
  parameter int unsigned      ID_WIDTH  = 4,
  parameter logic [WIDTH-1:0] MOD_RESET = {WIDTH{1'b0}}
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [1:0]          req_op_i,
  input  logic [WIDTH-1:0]    req_a_i,
  input  logic [WIDTH-1:0]    req_b_i,
  input  logic [ID_WIDTH-1:0] req_id_i,
  input  logic [4:0]          req_rd_i,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic [WIDTH-1:0]    res_data_o,
  output logic [ID_WIDTH-1:0] res_id_o,
  output logic [4:0]          res_rd_o,
  output logic                res_we_o,
  output logic [WIDTH-1:0]    mod_o
);

  typedef struct packed {
    ecc_alu_op_e         op;
    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
    logic [ID_WIDTH-1:0] id;
    logic [4:0]          rd;
  } req_t;

  ecc_alu_state_e      state_r, state_next_s;
  req_t                req_r;
  ecc_alu_op_e         op_in_s;
  logic                accept_s, res_fire_s;
  logic [WIDTH:0]      raw_s, raw_r;
  logic [WIDTH-1:0]    corr_s, mod_r;
  logic                req_ready_r, res_valid_r, res_we_r;
  logic [WIDTH-1:0]    res_data_r;
  logic [ID_WIDTH-1:0] res_id_r;
  logic [4:0]          res_rd_r;

  assign op_in_s    = ecc_alu_op_e'(req_op_i);
  assign accept_s   = req_valid_i & req_ready_r;
  assign res_fire_s = res_valid_r & res_ready_i;

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_r <= ST_IDLE;
    else       state_r <= state_next_s;
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (op_in_s == OP_SETMOD) state_next_s = ST_RESP;
          else                      state_next_s = ST_COMPUTE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_COMPUTE: state_next_s = ST_REDUCE;
      ST_REDUCE:  state_next_s = ST_RESP;
      ST_RESP: begin
        if (res_fire_s) state_next_s = ST_IDLE;
        else            state_next_s = ST_RESP;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Raw sum/difference; bit WIDTH carries the borrow for SUB/NEG
  always_comb begin
    raw_s = {1'b0, req_r.a};
    case (req_r.op)
      OP_ADD:  raw_s = {1'b0, req_r.a} + {1'b0, req_r.b};
      OP_SUB:  raw_s = {1'b0, req_r.a} - {1'b0, req_r.b};
      OP_NEG:  raw_s = {(WIDTH+1){1'b0}} - {1'b0, req_r.a};
      default: raw_s = {1'b0, req_r.a};
    endcase
  end

  ecc_mod_correct #(
    .WIDTH (WIDTH)
  ) u_correct (
    .raw     (raw_r),
    .modulus (mod_r),
    .op      (req_r.op),
    .result  (corr_s)
  );

  // Request latch, modulus register, pipeline and registered result channel
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_r       <= {$bits(req_t){1'b0}};
      raw_r       <= {(WIDTH+1){1'b0}};
      mod_r       <= MOD_RESET;
      req_ready_r <= 1'b1;
      res_valid_r <= 1'b0;
      res_data_r  <= {WIDTH{1'b0}};
      res_id_r    <= {ID_WIDTH{1'b0}};
      res_rd_r    <= 5'd0;
      res_we_r    <= 1'b0;
    end else begin
      req_ready_r <= (state_next_s == ST_IDLE);
      if (accept_s) begin
        req_r <= '{op: op_in_s, a: req_a_i, b: req_b_i, id: req_id_i, rd: req_rd_i};
      end
      if (accept_s && (op_in_s == OP_SETMOD)) begin
        mod_r <= req_a_i;
      end
      if (state_r == ST_COMPUTE) begin
        raw_r <= raw_s;
      end
      // SETMOD answers straight from the request; arithmetic answers from REDUCE
      if (accept_s && (op_in_s == OP_SETMOD)) begin
        res_valid_r <= 1'b1;
        res_data_r  <= req_a_i;
        res_id_r    <= req_id_i;
        res_rd_r    <= req_rd_i;
        res_we_r    <= 1'b0;
      end else if (state_r == ST_REDUCE) begin
        res_valid_r <= 1'b1;
        res_data_r  <= corr_s;
        res_id_r    <= req_r.id;
        res_rd_r    <= req_r.rd;
        res_we_r    <= 1'b1;
      end else if (res_fire_s) begin
        res_valid_r <= 1'b0;
      end
    end
  end

  assign req_ready_o = req_ready_r;
  assign res_valid_o = res_valid_r;
  assign res_data_o  = res_data_r;
  assign res_id_o    = res_id_r;
  assign res_rd_o    = res_rd_r;
  assign res_we_o    = res_we_r;
  assign mod_o       = mod_r;

endmodule

// File: tb/tb_ecc_modular_alu.sv
// Directed scoreboard bench for ecc_modular_alu: a 64-bit instance and an 8-bit instance
// share one request bus, selected by sel8.
module tb_ecc_modular_alu;
  import ecc_alu_pkg::*;

  localparam logic [63:0] P = 64'hFFFF_FFFF_0000_0001;

  logic        clk, rst, sel8;
  logic        req_valid, req_ready, res_valid, res_ready, res_we;
  logic [1:0]  req_op;
  logic [63:0] req_a, req_b, res_data, mod;
  logic [3:0]  req_id, res_id;
  logic [4:0]  req_rd, res_rd;

  logic        rdy64, val64, we64, rdy8, val8, we8;
  logic [63:0] data64, mod64;
  logic [7:0]  data8, mod8;
  logic [3:0]  id64, id8;
  logic [4:0]  rd64, rd8;

  ecc_modular_alu #(.WIDTH(64), .ID_WIDTH(4), .MOD_RESET(64'd0)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid & ~sel8), .req_ready_o(rdy64), .req_op_i(req_op),
    .req_a_i(req_a), .req_b_i(req_b), .req_id_i(req_id), .req_rd_i(req_rd),
    .res_valid_o(val64), .res_ready_i(res_ready & ~sel8), .res_data_o(data64),
    .res_id_o(id64), .res_rd_o(rd64), .res_we_o(we64), .mod_o(mod64)
  );

  ecc_modular_alu #(.WIDTH(8), .ID_WIDTH(4), .MOD_RESET(8'd0)) u_dut8 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid & sel8), .req_ready_o(rdy8), .req_op_i(req_op),
    .req_a_i(req_a[7:0]), .req_b_i(req_b[7:0]), .req_id_i(req_id), .req_rd_i(req_rd),
    .res_valid_o(val8), .res_ready_i(res_ready & sel8), .res_data_o(data8),
    .res_id_o(id8), .res_rd_o(rd8), .res_we_o(we8), .mod_o(mod8)
  );

  assign req_ready = sel8 ? rdy8 : rdy64;
  assign res_valid = sel8 ? val8 : val64;
  assign res_data  = sel8 ? {56'd0, data8} : data64;
  assign res_id    = sel8 ? id8 : id64;
  assign res_rd    = sel8 ? rd8 : rd64;
  assign res_we    = sel8 ? we8 : we64;
  assign mod       = sel8 ? {56'd0, mod8} : mod64;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  id;
    logic [4:0]  rd;
    logic        we;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge after the accept edge (cycle 1).
  task automatic send(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                      input logic [3:0] id, input logic [4:0] rd, input logic [63:0] exp_data,
                      input logic we, input int lat, input bit push);
    int n = 0;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_id = id; req_rd = rd;
    while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("req_ready_wait", {63'd0, req_ready}, 64'd1);
    if (push) exp_q.push_back('{exp_data, id, rd, we, lat});
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic collect(input string tag);
    int   cyc = 1;
    exp_t e;
    while (res_valid !== 1'b1 && cyc < 12) begin @(negedge clk); cyc++; end
    check({tag, "_valid"}, {63'd0, res_valid}, 64'd1);
    if (exp_q.size() == 0) begin
      n_vec++; n_err++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_lat"},  64'(cyc), 64'(e.lat));
      check({tag, "_data"}, res_data, e.data);
      check({tag, "_id"},   {60'd0, res_id}, {60'd0, e.id});
      check({tag, "_rd"},   {59'd0, res_rd}, {59'd0, e.rd});
      check({tag, "_we"},   {63'd0, res_we}, {63'd0, e.we});
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit seen;
    rst = 1'b1; sel8 = 1'b0; req_valid = 1'b0; res_ready = 1'b0;
    req_op = 2'd0; req_a = 64'd0; req_b = 64'd0; req_id = 4'd0; req_rd = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready", {63'd0, req_ready}, 64'd1);
    check("rst_valid", {63'd0, res_valid}, 64'd0);
    check("rst_mod",   mod, 64'd0);
    check("rst_data",  res_data, 64'd0);
    check("rst_we",    {63'd0, res_we}, 64'd0);
    check("rst_ready8", {63'd0, rdy8}, 64'd1);

    // SETMOD then arithmetic modulo p
    send(2'd0, P, 64'd0, 4'd3, 5'd5, P, 1'b0, 1, 1'b1);
    collect("setmod");
    check("setmod_mod", mod, P);
    send(2'd1, 64'hFFFF_FFFF_0000_0000, 64'd2, 4'd1, 5'd6, 64'd1, 1'b1, 3, 1'b1);
    collect("add_wrap");
    send(2'd2, 64'd1, 64'd2, 4'd2, 5'd7, 64'hFFFF_FFFF_0000_0000, 1'b1, 3, 1'b1);
    collect("sub_borrow");
    send(2'd3, 64'd0, 64'd9, 4'd4, 5'd8, 64'd0, 1'b1, 3, 1'b1);
    collect("neg_zero");
    send(2'd3, 64'd5, 64'd0, 4'd5, 5'd9, 64'hFFFF_FFFE_FFFF_FFFC, 1'b1, 3, 1'b1);
    collect("neg_five");
    send(2'd2, 64'd5, 64'd3, 4'd6, 5'd10, 64'd2, 1'b1, 3, 1'b1);
    collect("sub_plain");

    // Backpressure: result held, second request blocked
    send(2'd1, 64'hFFFF_FFFF_0000_0000, 64'd2, 4'd7, 5'd11, 64'd1, 1'b1, 3, 1'b0);
    cyc = 1;
    while (res_valid !== 1'b1 && cyc < 12) begin @(negedge clk); cyc++; end
    check("bp_lat", 64'(cyc), 64'd3);
    req_valid = 1'b1; req_op = 2'd2; req_a = 64'd1; req_b = 64'd2; req_id = 4'd8; req_rd = 5'd12;
    repeat (5) begin
      check("bp_valid", {63'd0, res_valid}, 64'd1);
      check("bp_data",  res_data, 64'd1);
      check("bp_id",    {60'd0, res_id}, 64'd7);
      check("bp_ready", {63'd0, req_ready}, 64'd0);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("bp_release_valid", {63'd0, res_valid}, 64'd0);
    check("bp_release_ready", {63'd0, req_ready}, 64'd1);
    exp_q.push_back('{64'hFFFF_FFFF_0000_0000, 4'd8, 5'd12, 1'b1, 3});
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    collect("bp_next");

    // Reset while in REDUCE: no result, modulus back to reset value
    send(2'd1, 64'd3, 64'd4, 4'd9, 5'd13, 64'd7, 1'b1, 3, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin seen |= res_valid; @(negedge clk); end
    check("rst_mid_valid", {63'd0, seen}, 64'd0);
    check("rst_mid_mod",   mod, 64'd0);
    check("rst_mid_ready", {63'd0, req_ready}, 64'd1);

    // p = 0 degenerates to plain wrap-around
    send(2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 4'd10, 5'd14, 64'd1, 1'b1, 3, 1'b1);
    collect("p0_add64");
    sel8 = 1'b1;
    @(negedge clk);
    send(2'd1, 64'hF0, 64'h20, 4'd11, 5'd15, 64'h10, 1'b1, 3, 1'b1);
    collect("w8_add");
    send(2'd2, 64'h01, 64'h02, 4'd12, 5'd16, 64'hFF, 1'b1, 3, 1'b1);
    collect("w8_sub");
    send(2'd3, 64'h01, 64'h00, 4'd13, 5'd17, 64'hFF, 1'b1, 3, 1'b1);
    collect("w8_neg");
    check("w8_mod", mod, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ecc_modular_alu.md
Name: ecc_modular_alu

Overview:
- Parametrised modular arithmetic engine for the ECC CV-X-IF coprocessor; successor to the fixed 64-bit add/sub units.
- Holds its own modulus register and executes SETMOD, ADD, SUB and NEG modulo p at configurable operand width.
- Uses a valid/ready request channel and a valid/ready result channel carrying id/rd/we for the coprocessor's result path.
- One operation is in flight at a time. The result is held until it is accepted.

Parameters:
WIDTH, 64, operand/modulus width in bits (>=8)
ID_WIDTH, 4, width of the instruction id tag
MOD_RESET, '0, modulus register value after reset

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
req_valid_i  in  1  request valid
req_ready_o  out  1  request ready (engine idle)
req_op_i  in  2  0=SETMOD 1=ADD 2=SUB 3=NEG
req_a_i  in  WIDTH  operand a (new modulus for SETMOD)
req_b_i  in  WIDTH  operand b (ignored by SETMOD/NEG)
req_id_i  in  ID_WIDTH  instruction id
req_rd_i  in  5  destination register
res_valid_o  out  1  result valid
res_ready_i  in  1  result accepted
res_data_o  out  WIDTH  result value
res_id_o  out  ID_WIDTH  echoed id
res_rd_o  out  5  echoed rd
res_we_o  out  1  writeback enable (0 for SETMOD)
mod_o  out  WIDTH  current modulus

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset values: state=IDLE, req_ready_o=1, res_valid_o=0, res_data_o/res_id_o/res_rd_o/res_we_o=0, modulus=MOD_RESET.
- Reset is honoured mid-operation: in-flight work is dropped and no result is emitted.
- FSM states: IDLE, COMPUTE, REDUCE, RESP.
- req_ready_o is high only in IDLE. A request is accepted when req_valid_i&req_ready_o at a clock edge; op, a, b, id and rd are latched there.
- IDLE --accept SETMOD--> RESP:
  - modulus <= a at the accept edge.
  - res_data_o = a, res_we_o = 0.
  - res_valid_o is high on the cycle after accept (latency 1).
- IDLE --accept ADD/SUB/NEG--> COMPUTE --> REDUCE --> RESP:
  - res_valid_o is high 3 cycles after the accept edge.
  - res_we_o = 1.
- RESP: outputs are held stable while res_valid_o=1 && !res_ready_i. On res_valid_o&res_ready_i, go to IDLE and clear res_valid_o.
  - There is no accept in the same cycle as the result handshake; the next request can be accepted at the earliest one cycle later.
- COMPUTE registers the raw (WIDTH+1)-bit value:
  - ADD: s = a+b
  - SUB: s = a-b, with borrow in bit WIDTH
  - NEG: s = 0-a
- REDUCE registers the corrected WIDTH-bit value:
  - ADD: s>=p (WIDTH+1-bit compare) ? s-p : s
  - SUB/NEG: borrow ? s+p : s
  - NEG with a=0 yields 0.
- Single correction only. Operands >= p give the defined single-correction value; no full reduction is performed.
- p=0: all ops degenerate to wrap-around mod 2^WIDTH (ADD subtracts 0, SUB/NEG add 0).
- A modulus written by SETMOD is used by the next accepted op.
- mod_o always reflects the register.
- The id/rd/op latched at accept is echoed unchanged. The result uses p as read in REDUCE; p cannot change during an op because SETMOD cannot be accepted while busy.

Decomposition:
- ecc_alu_pkg holds:
  - op enum ecc_alu_op_e (SETMOD/ADD/SUB/NEG)
  - FSM enum ecc_alu_state_e
  - request struct ecc_alu_req_t {op,a,b,id,rd}, parametrised via WIDTH localparam
- One sub-module: ecc_mod_correct. It is combinational: it takes the raw (WIDTH+1)-bit value, p and op, and returns the corrected value. It is instantiated in the REDUCE stage.

Test Plan:
- Reset: hold rst_i 2 cycles with MOD_RESET=0 -> req_ready_o=1, res_valid_o=0, mod_o=0.
- SETMOD with a=0xFFFFFFFF00000001, id=3, rd=5 -> next cycle res_valid_o=1, res_data_o=a, res_we_o=0, res_id_o=3, mod_o=a.
- With p=0xFFFFFFFF00000001:
  - ADD a=0xFFFFFFFF00000000, b=2 -> res_data_o=1 at accept+3.
  - SUB a=1, b=2 -> 0xFFFFFFFF00000000.
  - NEG a=0 -> 0.
- Backpressure: hold res_ready_i=0 for 5 cycles during an ADD result -> outputs stable, req_ready_o=0, a second req_valid_i is not accepted. Then assert res_ready_i -> IDLE, and the next request is accepted one cycle later.
- Reset mid-op: assert rst_i in REDUCE -> res_valid_o never rises, modulus returns to MOD_RESET.
- p=0 wrap with WIDTH=8:
  - ADD 0xF0+0x20 -> 0x10.
  - SUB 0x01-0x02 -> 0xFF.
